i2s_master: RTL

I2S_MASTER -- requirements
Module: i2s_master

---
 rtl/i2s_pkg.sv | 20 ++
 rtl/i2s_clk_div.sv | 35 +++
 rtl/i2s_master.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S constants, stereo sample layout and a saturating increment helper.
package i2s_pkg;

  localparam int FRAME_BITS    = 64;
  localparam int CH_BITS       = 32;
  localparam int SAMPLE_PAIR_W = 48;
  localparam int CH_W          = SAMPLE_PAIR_W / 2;
  localparam int BIT_CNT_W     = $clog2(FRAME_BITS);

  // left occupies the upper half so the struct lines up with data[47:24]
  typedef struct packed {
    logic [CH_W-1:0] left;
    logic [CH_W-1:0] right;
  } i2s_sample_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// Bit-clock generator: registered bclk plus single-cycle rise/fall strobes,
// all in the clk domain. Strobes mark the cycle whose clock edge moves bclk.
module i2s_clk_div #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  output logic o_bclk,
  output logic o_rise,
  output logic o_fall
);

  logic [7:0] r_div;
  logic       r_bclk;
  logic       w_tc;

  assign w_tc = (r_div == 8'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div  <= 8'd0;
      r_bclk <= 1'b0;
    end else if (w_tc) begin
      r_div  <= 8'd0;
      r_bclk <= ~r_bclk;
    end else begin
      r_div <= r_div + 8'd1;
    end
  end

  assign o_bclk = r_bclk;
  assign o_rise = w_tc & ~r_bclk;
  assign o_fall = w_tc & r_bclk;

endmodule

// File: rtl/i2s_master.sv
// I2S master: 64-bit frames, one-bit-delayed MSB-first stereo, tx/rx valid-ready.
// Defining I2S_MASTER_ERR_CNT_EN adds saturating underflow/overflow counters.
module i2s_master
  import i2s_pkg::*;
#(
  parameter int CLK_DIV  = 8,
  parameter int SAMPLE_W = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_tx_valid,
  output logic                     o_tx_ready,
  input  logic [SAMPLE_PAIR_W-1:0] i_tx_data,
  output logic                     o_rx_valid,
  input  logic                     i_rx_ready,
  output logic [SAMPLE_PAIR_W-1:0] o_rx_data,
  output logic                     o_bclk,
  output logic                     o_lrclk,
  output logic                     o_sdata,
  input  logic                     i_sdata
`ifdef I2S_MASTER_ERR_CNT_EN
  ,
  output logic [15:0]              o_underflow_count,
  output logic [15:0]              o_overflow_count
`endif
);

  localparam int                 RX_CAP   = (SAMPLE_W < CH_W) ? SAMPLE_W : CH_W;
  localparam logic [4:0]         SW5      = 5'(SAMPLE_W);
  localparam logic [4:0]         RX_MAX   = 5'(RX_CAP);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(CH_BITS + SAMPLE_W);

  logic                 w_bclk;
  logic                 w_rise;
  logic                 w_fall;
  logic [BIT_CNT_W-1:0] r_bit;
  logic [BIT_CNT_W-1:0] w_nbit;
  logic                 r_lrclk;
  logic                 r_sdata;
  logic                 r_tx_ready;
  logic                 r_active;
  i2s_sample_t          r_tx;
  i2s_sample_t          r_rx_sh;
  i2s_sample_t          w_rx_nxt;
  i2s_sample_t          r_rx_data;
  logic                 r_rx_valid;
  logic                 w_tx_slot;
  logic                 w_rx_slot;
  logic                 w_rx_done;
  logic [4:0]           w_rx_idx;

  i2s_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk    (clk),
    .reset  (reset),
    .o_bclk (w_bclk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // tx decisions look at the bit being entered, rx at the bit currently on the wire
  assign w_nbit    = r_bit + 1'b1;
  assign w_tx_slot = (w_nbit[4:0] != 5'd0) && (w_nbit[4:0] <= SW5);
  assign w_rx_slot = r_active && (r_bit[4:0] != 5'd0) && (r_bit[4:0] <= RX_MAX);
  assign w_rx_idx  = 5'(CH_W) - r_bit[4:0];
  assign w_rx_done = w_rise && r_active && (r_bit == LAST_BIT);

  always_comb begin
    w_rx_nxt = r_rx_sh;
    if (w_rise && w_rx_slot) begin
      if (r_bit[5]) w_rx_nxt.right[w_rx_idx] = i_sdata;
      else          w_rx_nxt.left[w_rx_idx]  = i_sdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bit      <= '1;
      r_lrclk    <= 1'b1;
      r_sdata    <= 1'b0;
      r_tx_ready <= 1'b0;
      r_active   <= 1'b0;
      r_tx       <= '0;
    end else begin
      r_tx_ready <= w_fall && (w_nbit == '0);
      if (w_fall) begin
        r_active <= 1'b1;
        r_bit    <= w_nbit;
        r_lrclk  <= w_nbit[5];
        if (w_tx_slot) begin
          if (w_nbit[5]) begin
            r_sdata    <= r_tx.right[CH_W-1];
            r_tx.right <= {r_tx.right[CH_W-2:0], 1'b0};
          end else begin
            r_sdata   <= r_tx.left[CH_W-1];
            r_tx.left <= {r_tx.left[CH_W-2:0], 1'b0};
          end
        end else begin
          r_sdata <= 1'b0;
        end
      end else if (r_tx_ready) begin
        // underflow sends a silent frame
        r_tx <= i_tx_valid ? i2s_sample_t'(i_tx_data) : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_sh <= w_rx_nxt;
      if (w_rx_done) begin
        r_rx_data  <= w_rx_nxt;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

`ifdef I2S_MASTER_ERR_CNT_EN
  logic [15:0] r_uf_cnt;
  logic [15:0] r_of_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_uf_cnt <= 16'd0;
      r_of_cnt <= 16'd0;
    end else begin
      if (r_tx_ready && !i_tx_valid)
        r_uf_cnt <= sat_inc16(r_uf_cnt);
      // a handshake completing in the same cycle is not an overflow
      if (w_rx_done && r_rx_valid && !i_rx_ready)
        r_of_cnt <= sat_inc16(r_of_cnt);
    end
  end

  assign o_underflow_count = r_uf_cnt;
  assign o_overflow_count  = r_of_cnt;
`endif

  assign o_tx_ready = r_tx_ready;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_data;
  assign o_bclk     = w_bclk;
  assign o_lrclk    = r_lrclk;
  assign o_sdata    = r_sdata;

endmodule
